// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: bus widths, chip-enable levels, fetch state encodings and reset PC
package inst_fetch_pkg;
   localparam int INST_ADDR_W = 32;
   localparam int INST_W = 32;
   localparam logic CHIP_ENABLE = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;
   localparam logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000;
   typedef enum logic [1:0] {IF_IDLE, IF_RUN, IF_ERR} if_state_e;
endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, reads the instruction ROM and hands one entry at a time to decode.
// IF_DELAY_SLOT_EN: when defined, the fetch in flight during a branch is kept as the delay slot.
module inst_fetch
   import inst_fetch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   output logic                   rom_ce_o,
   output logic [INST_ADDR_W-1:0] rom_addr_o,
   input  logic [INST_W-1:0]      rom_inst_i,
   output logic                   if_valid_o,
   input  logic                   id_ready_i,
   output logic [INST_ADDR_W-1:0] if_pc_o,
   output logic [INST_W-1:0]      if_inst_o,
   output logic                   if_adel_o,
   input  logic                   branch_flag_i,
   input  logic [INST_ADDR_W-1:0] branch_target_i,
   input  logic                   flush_i,
   input  logic [INST_ADDR_W-1:0] new_pc_i
);
   if_state_e state_q, state_d;
   logic [INST_ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic valid_q, valid_d, adel_q, adel_d, ce_q, ce_d;
   logic squash, adv;
`ifdef IF_DELAY_SLOT_EN
   assign squash = 1'b0;
`else
   assign squash = branch_flag_i;
`endif
   assign adv = (state_q == IF_RUN) && (!valid_q || id_ready_i) && !squash && !flush_i;
   always_comb begin
      state_d = (state_q == IF_IDLE) ? IF_RUN : state_q;
      pc_d = pc_q;
      valid_d = valid_q;
      epc_d = epc_q;
      inst_d = inst_q;
      adel_d = adel_q;
      if (adv) begin
         epc_d = pc_q;
         valid_d = 1'b1;
         adel_d = (pc_q[1:0] != 2'b00);
         inst_d = adel_d ? '0 : rom_inst_i;
         pc_d = adel_d ? pc_q : pc_q + 32'd4;
         state_d = adel_d ? IF_ERR : IF_RUN;
      end else if ((valid_q && id_ready_i) || squash) begin
         valid_d = 1'b0;
      end
      if (branch_flag_i) pc_d = branch_target_i;
      // a flush wins over everything, including an accept in the same cycle
      if (flush_i) begin
         valid_d = 1'b0;
         pc_d = new_pc_i;
         state_d = IF_RUN;
      end
      ce_d = (state_d == IF_IDLE) ? CHIP_DISABLE : CHIP_ENABLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IF_IDLE;
         pc_q <= RESET_PC;
         valid_q <= 1'b0;
         epc_q <= '0;
         inst_q <= '0;
         adel_q <= 1'b0;
         ce_q <= CHIP_DISABLE;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         valid_q <= valid_d;
         epc_q <= epc_d;
         inst_q <= inst_d;
         adel_q <= adel_d;
         ce_q <= ce_d;
      end
   end
   assign rom_ce_o = ce_q;
   assign rom_addr_o = pc_q;
   assign if_valid_o = valid_q;
   assign if_pc_o = epc_q;
   assign if_inst_o = inst_q;
   assign if_adel_o = adel_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed plan steps plus random traffic checked against an entry-level reference model.
module tb_inst_fetch;
   logic clk = 1'b0, rst = 1'b1;
   logic rom_ce_o, if_valid_o, if_adel_o;
   logic id_ready_i = 1'b0, branch_flag_i = 1'b0, flush_i = 1'b0;
   logic [31:0] rom_addr_o, rom_inst_i, if_pc_o, if_inst_o;
   logic [31:0] branch_target_i = '0, new_pc_i = '0;
   int tests = 0, fails = 0;
   int m_mode;
   bit m_valid, m_adel;
   logic [31:0] m_pc, m_epc, m_inst;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      logic [31:0] w [4];
      w = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      return (a < 32'd16) ? w[a[3:2]] : (a ^ 32'h5A5A_0F0F);
   endfunction
   assign rom_inst_i = rom_word(rom_addr_o);

   inst_fetch dut (
      .clk(clk), .rst(rst), .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_inst_i(rom_inst_i),
      .if_valid_o(if_valid_o), .id_ready_i(id_ready_i), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
      .if_adel_o(if_adel_o), .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
      .flush_i(flush_i), .new_pc_i(new_pc_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_valid = 0; m_adel = 0; m_pc = 32'h0; m_epc = 32'h0; m_inst = 32'h0;
   endtask

   // mode: 0 idle, 1 fetching, 2 halted on a misaligned entry
   task automatic model_edge(input bit rdy, input bit br, input logic [31:0] tgt, input bit fl, input logic [31:0] npc);
      bit drop;
`ifdef IF_DELAY_SLOT_EN
      drop = 0;
`else
      drop = br;
`endif
      if (fl) begin
         m_valid = 0; m_pc = npc; m_mode = 1;
      end else begin
         if (m_mode == 1 && (!m_valid || rdy) && !drop) begin
            m_epc = m_pc; m_valid = 1;
            if (m_pc % 4 == 0) begin
               m_inst = rom_word(m_pc); m_adel = 0; m_pc = m_pc + 32'd4;
            end else begin
               m_inst = 32'h0; m_adel = 1; m_mode = 2;
            end
         end else if (m_valid && rdy || drop) m_valid = 0;
         if (br) m_pc = tgt;
         if (m_mode == 0) m_mode = 1;
      end
   endtask

   task automatic check_model();
      chk("ce", {31'b0, rom_ce_o}, {31'b0, m_mode != 0});
      chk("addr", rom_addr_o, m_pc);
      chk("valid", {31'b0, if_valid_o}, {31'b0, m_valid});
      if (m_valid) begin
         chk("entry_pc", if_pc_o, m_epc);
         chk("entry_inst", if_inst_o, m_inst);
         chk("entry_adel", {31'b0, if_adel_o}, {31'b0, m_adel});
      end
   endtask

   task automatic step(input bit rdy, input bit br, input logic [31:0] tgt, input bit fl, input logic [31:0] npc);
      id_ready_i = rdy; branch_flag_i = br; branch_target_i = tgt; flush_i = fl; new_pc_i = npc;
      @(posedge clk);
      model_edge(rdy, br, tgt, fl, npc);
      #1;
      check_model();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ce"}, {31'b0, rom_ce_o}, 32'h0);
      chk({tag, "_addr"}, rom_addr_o, 32'h0);
      chk({tag, "_valid"}, {31'b0, if_valid_o}, 32'h0);
      chk({tag, "_pc"}, if_pc_o, 32'h0);
      chk({tag, "_inst"}, if_inst_o, 32'h0);
      chk({tag, "_adel"}, {31'b0, if_adel_o}, 32'h0);
   endtask

   initial begin
      logic [31:0] t, n;
      bit r, b, f;
      model_reset();
      @(posedge clk); #1;
      chk_zero("reset");
      @(negedge clk); rst = 1'b0;
      step(1, 0, 0, 0, 0);
      chk("e1_valid", {31'b0, if_valid_o}, 32'h0);
      step(1, 0, 0, 0, 0);
      chk("e2_pc", if_pc_o, 32'h0);
      chk("e2_inst", if_inst_o, 32'h1111_1111);
      step(1, 0, 0, 0, 0);
      chk("seq_pc4", if_pc_o, 32'h4);
      step(1, 0, 0, 0, 0);
      chk("seq_pc8", if_pc_o, 32'h8);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0);
         chk("hold_pc", if_pc_o, 32'h8);
         chk("hold_inst", if_inst_o, 32'h3333_3333);
      end
      step(1, 0, 0, 0, 0);
      chk("resume_pc", if_pc_o, 32'hC);
      step(1, 0, 0, 1, 32'h0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("pre_branch_pc", if_pc_o, 32'h4);
      step(1, 1, 32'h40, 0, 0);
`ifdef IF_DELAY_SLOT_EN
      chk("ds_slot_pc", if_pc_o, 32'h8);
      chk("ds_slot_valid", {31'b0, if_valid_o}, 32'h1);
`else
      chk("bubble_valid", {31'b0, if_valid_o}, 32'h0);
`endif
      step(1, 0, 0, 0, 0);
      chk("target_pc", if_pc_o, 32'h40);
      step(0, 0, 0, 1, 32'h180);
      chk("flush_valid", {31'b0, if_valid_o}, 32'h0);
      step(0, 0, 0, 0, 0);
      chk("flush_pc", if_pc_o, 32'h180);
      step(1, 1, 32'h42, 0, 0);
      step(1, 0, 0, 0, 0);
`ifdef IF_DELAY_SLOT_EN
      step(1, 0, 0, 0, 0);
`endif
      chk("adel_pc", if_pc_o, 32'h42);
      chk("adel_flag", {31'b0, if_adel_o}, 32'h1);
      chk("adel_inst", if_inst_o, 32'h0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      chk("err_halt", {31'b0, if_valid_o}, 32'h0);
      step(1, 0, 0, 1, 32'h180);
      step(1, 0, 0, 0, 0);
      chk("err_resume", if_pc_o, 32'h180);
      step(1, 0, 0, 1, 32'hFFFF_FFFC);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("wrap_pc", if_pc_o, 32'h0);
      chk("wrap_adel", {31'b0, if_adel_o}, 32'h0);
      for (int i = 0; i < 500; i++) begin
         r = ($urandom % 4) != 0;
         f = ($urandom % 25) == 0;
         b = !f && m_mode == 1 && m_valid && r && ($urandom % 6) == 0;
         t = $urandom & 32'hFFFF_FFFC;
         if ($urandom % 8 == 0) t[1:0] = 2'b10;
         n = $urandom & 32'hFFFF_FFFC;
         if ($urandom % 10 == 0) n[0] = 1'b1;
         step(r, b, t, f, n);
      end
      step(1, 0, 0, 1, 32'h100);
      step(1, 0, 0, 0, 0);
      #3 rst = 1'b1;
      #1 chk_zero("midreset");
      model_reset();
      @(negedge clk); rst = 1'b0;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("restart_inst", if_inst_o, 32'h1111_1111);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
